// File: rtl/vx_cache_bank_sched_pkg.sv
// Shared types for the cache bank arbitration stage: issued op encoding and
// scheduler state encoding.
package VX_cache_pkg;

    typedef enum logic [1:0] {
        CS_OP_CORE   = 2'd0,
        CS_OP_FILL   = 2'd1,
        CS_OP_REPLAY = 2'd2,
        CS_OP_FLUSH  = 2'd3
    } cs_op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_WAIT = 2'd1,
        REPLAY    = 2'd2,
        FLUSH     = 2'd3
    } sched_state_t;

    // Index width for a counter over n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_cache_sched_obuf.sv
// One-entry valid/ready output register. Loads whenever it is empty or its
// current content is being taken; otherwise holds the payload stable.
module vx_cache_sched_obuf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             load_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign load_ready = !valid_q || out_ready;
    assign out_valid  = valid_q;
    assign out_data   = data_q;

    // Next register content: take a new op when loadable, else keep the current one.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Register update; payload is cleared too so all issue fields read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/vx_cache_bank_sched.sv
// Cache bank arbitration stage: picks one of flush / fill / MSHR replay / core
// request per cycle and issues it through a one-entry output register. A fill
// starts a replay chain that must fully drain before another fill is taken,
// since a new fill would move the MSHR dequeue pointer mid-chain.
module vx_cache_bank_sched
    import VX_cache_pkg::*;
#(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int MSHR_SIZE       = 4,
    parameter int MSHR_ADDR_WIDTH = 2,
    parameter int REQ_DATAW       = 64,
    parameter int LINE_WIDTH      = 128,
    parameter int NUM_LINES       = 64,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       core_req_valid,
    output logic                       core_req_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] core_req_addr,
    input  logic                       core_req_rw,
    input  logic [REQ_DATAW-1:0]       core_req_data,
    input  logic                       mem_rsp_valid,
    output logic                       mem_rsp_ready,
    input  logic [MSHR_ADDR_WIDTH-1:0] mem_rsp_id,
    input  logic [LINE_WIDTH-1:0]      mem_rsp_data,
    output logic                       mshr_fill_valid,
    output logic [MSHR_ADDR_WIDTH-1:0] mshr_fill_id,
    input  logic [LINE_ADDR_WIDTH-1:0] mshr_fill_addr,
    input  logic                       mshr_deq_valid,
    output logic                       mshr_deq_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] mshr_deq_addr,
    input  logic                       mshr_deq_rw,
    input  logic [REQ_DATAW-1:0]       mshr_deq_data,
    input  logic [MSHR_ADDR_WIDTH-1:0] mshr_deq_id,
    input  logic                       mshr_alloc_ready,
    input  logic                       mshr_empty,
    input  logic                       flush_begin,
    output logic                       flush_done,
    output logic                       pipe_valid,
    input  logic                       pipe_ready,
    output logic [1:0]                 pipe_op,
    output logic [LINE_ADDR_WIDTH-1:0] pipe_addr,
    output logic                       pipe_rw,
    output logic [REQ_DATAW-1:0]       pipe_data,
    output logic [LINE_WIDTH-1:0]      pipe_line,
    output logic [MSHR_ADDR_WIDTH-1:0] pipe_id,
    output logic                       busy
);

    localparam int IDXW = idx_width(NUM_LINES);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int PW   = 2 + LINE_ADDR_WIDTH + 1 + REQ_DATAW + LINE_WIDTH + MSHR_ADDR_WIDTH;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_LINES - 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    sched_state_t    state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [IDXW-1:0] flush_idx_q, flush_idx_d;
    logic            flush_last_q, flush_last_d;

    logic load_ready, flush_block, core_wins, in_idle;
    logic fill_acc, core_acc, deq_acc, flush_load, issue_valid;

    cs_op_t                     iss_op;
    logic [LINE_ADDR_WIDTH-1:0] iss_addr;
    logic                       iss_rw;
    logic [REQ_DATAW-1:0]       iss_data;
    logic [LINE_WIDTH-1:0]      iss_line;
    logic [MSHR_ADDR_WIDTH-1:0] iss_id;
    logic [PW-1:0]              out_data;

    // A pending flush with an empty MSHR owns the IDLE slot until FLUSH is entered.
    assign flush_block = flush_pend_q && mshr_empty;
    assign core_wins   = (starve_cnt_q == STARVE_MAX);
    assign in_idle     = (state_q == IDLE);

    // Fill acceptance is masked during reset so the bank does not appear to take a line it will drop.
    assign mem_rsp_ready  = !reset && load_ready && in_idle && !flush_block && !core_wins;
    assign core_req_ready = load_ready && in_idle && mshr_alloc_ready && !flush_block &&
                            (!mem_rsp_valid || core_wins);
    assign mshr_deq_ready = load_ready && (state_q == REPLAY);

    assign fill_acc   = mem_rsp_valid && mem_rsp_ready;
    assign core_acc   = core_req_valid && core_req_ready;
    assign deq_acc    = mshr_deq_valid && mshr_deq_ready;
    assign flush_load = (state_q == FLUSH) && load_ready && !flush_last_q;
    assign issue_valid = fill_acc || core_acc || deq_acc || flush_load;

    assign mshr_fill_valid = fill_acc;
    assign mshr_fill_id    = fill_acc ? mem_rsp_id : '0;
    assign flush_done      = (state_q == FLUSH) && flush_last_q && pipe_valid && pipe_ready;
    assign busy            = !in_idle || flush_pend_q || pipe_valid;

    // Build the issue payload for whichever source was accepted this cycle.
    always_comb begin
        iss_op   = CS_OP_CORE;
        iss_addr = '0;
        iss_rw   = 1'b0;
        iss_data = '0;
        iss_line = '0;
        iss_id   = '0;
        if (fill_acc) begin
            iss_op   = CS_OP_FILL;
            iss_addr = mshr_fill_addr;
            iss_line = mem_rsp_data;
            iss_id   = mem_rsp_id;
        end else if (deq_acc) begin
            iss_op   = CS_OP_REPLAY;
            iss_addr = mshr_deq_addr;
            iss_rw   = mshr_deq_rw;
            iss_data = mshr_deq_data;
            iss_id   = mshr_deq_id;
        end else if (flush_load) begin
            iss_op   = CS_OP_FLUSH;
            iss_addr = LINE_ADDR_WIDTH'(flush_idx_q);
        end else if (core_acc) begin
            iss_addr = core_req_addr;
            iss_rw   = core_req_rw;
            iss_data = core_req_data;
        end
    end

    // Scheduler sequencing, flush bookkeeping and core starvation counter.
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q || flush_begin;
        starve_cnt_d = starve_cnt_q;
        flush_idx_d  = flush_idx_q;
        flush_last_d = flush_last_q;
        case (state_q)
            IDLE: begin
                if (fill_acc) begin
                    state_d = FILL_WAIT;
                end else if (flush_block && load_ready) begin
                    state_d      = FLUSH;
                    flush_pend_d = flush_begin;
                end
            end
            // MSHR dequeue valid lags the fill by one cycle.
            FILL_WAIT: state_d = REPLAY;
            REPLAY: begin
                if (!mshr_deq_valid) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_load) begin
                    flush_last_d = (flush_idx_q == LAST_IDX);
                    flush_idx_d  = (flush_idx_q == LAST_IDX) ? '0 : flush_idx_q + 1'b1;
                end
                if (flush_done) begin
                    state_d      = IDLE;
                    flush_last_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!core_req_valid || core_acc) begin
            starve_cnt_d = '0;
        end else if (fill_acc && mshr_alloc_ready && !core_wins) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            starve_cnt_q <= '0;
            flush_idx_q  <= '0;
            flush_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            starve_cnt_q <= starve_cnt_d;
            flush_idx_q  <= flush_idx_d;
            flush_last_q <= flush_last_d;
        end
    end

    vx_cache_sched_obuf #(
        .WIDTH (PW)
    ) u_obuf (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (issue_valid),
        .in_data    ({iss_op, iss_addr, iss_rw, iss_data, iss_line, iss_id}),
        .load_ready (load_ready),
        .out_valid  (pipe_valid),
        .out_ready  (pipe_ready),
        .out_data   (out_data)
    );

    assign {pipe_op, pipe_addr, pipe_rw, pipe_data, pipe_line, pipe_id} = out_data;

endmodule

// File: tb/tb_vx_cache_bank_sched.sv
// Randomized bench for vx_cache_bank_sched with a transaction-level reference
// model and a scoreboard queue of expected issued ops.
module tb_vx_cache_bank_sched;

    localparam int LA = 26;
    localparam int MS = 4;
    localparam int MA = 2;
    localparam int RD = 64;
    localparam int LW = 128;
    localparam int NL = 4;
    localparam int SL = 2;

    localparam logic [1:0] OP_CORE = 2'd0, OP_FILL = 2'd1, OP_REPLAY = 2'd2, OP_FLUSH = 2'd3;
    localparam int M_IDLE = 0, M_FW = 1, M_REPLAY = 2, M_FLUSH = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          core_req_valid = 0, core_req_ready, core_req_rw = 0;
    logic [LA-1:0] core_req_addr = '0;
    logic [RD-1:0] core_req_data = '0;
    logic          mem_rsp_valid = 0, mem_rsp_ready;
    logic [MA-1:0] mem_rsp_id = '0;
    logic [LW-1:0] mem_rsp_data = '0;
    logic          mshr_fill_valid;
    logic [MA-1:0] mshr_fill_id;
    logic [LA-1:0] mshr_fill_addr;
    logic          mshr_deq_valid = 0, mshr_deq_ready, mshr_deq_rw = 0;
    logic [LA-1:0] mshr_deq_addr = '0;
    logic [RD-1:0] mshr_deq_data = '0;
    logic [MA-1:0] mshr_deq_id = '0;
    logic          mshr_alloc_ready = 1, mshr_empty = 0, flush_begin = 0, flush_done;
    logic          pipe_valid, pipe_ready = 1, pipe_rw, busy;
    logic [1:0]    pipe_op;
    logic [LA-1:0] pipe_addr;
    logic [RD-1:0] pipe_data;
    logic [LW-1:0] pipe_line;
    logic [MA-1:0] pipe_id;

    logic [LA-1:0] mshr_tab [MS];
    assign mshr_fill_addr = mshr_tab[mem_rsp_id];

    vx_cache_bank_sched #(
        .LINE_ADDR_WIDTH(LA), .MSHR_SIZE(MS), .MSHR_ADDR_WIDTH(MA), .REQ_DATAW(RD),
        .LINE_WIDTH(LW), .NUM_LINES(NL), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_addr(core_req_addr), .core_req_rw(core_req_rw), .core_req_data(core_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
        .mshr_fill_valid(mshr_fill_valid), .mshr_fill_id(mshr_fill_id), .mshr_fill_addr(mshr_fill_addr),
        .mshr_deq_valid(mshr_deq_valid), .mshr_deq_ready(mshr_deq_ready),
        .mshr_deq_addr(mshr_deq_addr), .mshr_deq_rw(mshr_deq_rw), .mshr_deq_data(mshr_deq_data),
        .mshr_deq_id(mshr_deq_id), .mshr_alloc_ready(mshr_alloc_ready), .mshr_empty(mshr_empty),
        .flush_begin(flush_begin), .flush_done(flush_done),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_op(pipe_op), .pipe_addr(pipe_addr),
        .pipe_rw(pipe_rw), .pipe_data(pipe_data), .pipe_line(pipe_line), .pipe_id(pipe_id),
        .busy(busy)
    );

    typedef struct packed {
        logic [1:0]    op;
        logic [LA-1:0] addr;
        logic          rw;
        logic [RD-1:0] data;
        logic [LW-1:0] line;
        logic [MA-1:0] id;
    } item_t;

    item_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: a transaction-level view of what the scheduler is doing.
    int m_mode = M_IDLE;
    bit m_pend = 0;
    int m_starve = 0;
    int m_sent = 0;
    bit m_pv = 0;
    int m_core_wins_seen = 0;
    int m_flush_done_seen = 0;

    // Stimulus knobs, percent probability per cycle.
    int p_core = 0, p_mem = 0, p_deq = 0, p_alloc = 100, p_empty = 0, p_flush = 0, p_ready = 100;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic drive(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            core_req_valid   = roll(p_core);
            core_req_addr    = LA'($urandom);
            core_req_rw      = 1'($urandom);
            core_req_data    = {$urandom, $urandom};
            mem_rsp_valid    = roll(p_mem);
            mem_rsp_id       = MA'($urandom);
            mem_rsp_data     = {$urandom, $urandom, $urandom, $urandom};
            mshr_deq_valid   = roll(p_deq);
            mshr_deq_addr    = LA'($urandom);
            mshr_deq_rw      = 1'($urandom);
            mshr_deq_data    = {$urandom, $urandom};
            mshr_deq_id      = MA'($urandom);
            mshr_alloc_ready = roll(p_alloc);
            mshr_empty       = roll(p_empty);
            flush_begin      = roll(p_flush);
            pipe_ready       = roll(p_ready);
        end
    endtask

    task automatic knobs(input int c, input int m, input int d, input int a, input int e,
                         input int f, input int r);
        p_core = c; p_mem = m; p_deq = d; p_alloc = a; p_empty = e; p_flush = f; p_ready = r;
    endtask

    task automatic quiet_inputs();
        core_req_valid = 0; mem_rsp_valid = 0; mshr_deq_valid = 0; flush_begin = 0;
        mshr_alloc_ready = 1; mshr_empty = 0; pipe_ready = 1;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = 0; m_starve = 0; m_sent = 0; m_pv = 0;
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pipe_valid"}, pipe_valid, 0);
        chk({tag, "_mem_rsp_ready"}, mem_rsp_ready, 0);
        chk({tag, "_mshr_fill_valid"}, mshr_fill_valid, 0);
        chk({tag, "_mshr_fill_id"}, mshr_fill_id, 0);
        chk({tag, "_mshr_deq_ready"}, mshr_deq_ready, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pipe_op"}, pipe_op, 0);
        chk({tag, "_pipe_addr"}, pipe_addr, 0);
        chk({tag, "_pipe_data"}, pipe_data, 0);
        chk({tag, "_pipe_line"}, pipe_line, 0);
        chk({tag, "_pipe_id"}, pipe_id, 0);
    endtask

    // Reference model: predicts handshakes from the arbitration rules and queues expected issues.
    always @(negedge clk) begin : model_p
        bit room, fblk, cw, e_mem, e_core, e_deq, e_done, e_busy, fill, core, rep, fl;
        item_t it;
        if (!reset) begin
            room   = !m_pv || pipe_ready;
            fblk   = m_pend && mshr_empty;
            cw     = (m_starve == SL);
            e_mem  = room && m_mode == M_IDLE && !fblk && !cw;
            e_core = room && m_mode == M_IDLE && mshr_alloc_ready && !fblk && (!mem_rsp_valid || cw);
            e_deq  = room && m_mode == M_REPLAY;
            e_done = m_mode == M_FLUSH && m_sent == NL && m_pv && pipe_ready;
            e_busy = m_mode != M_IDLE || m_pend || m_pv;
            chk("mem_rsp_ready", mem_rsp_ready, e_mem);
            chk("core_req_ready", core_req_ready, e_core);
            chk("mshr_deq_ready", mshr_deq_ready, e_deq);
            chk("flush_done", flush_done, e_done);
            chk("busy", busy, e_busy);
            fill = mem_rsp_valid && e_mem;
            core = core_req_valid && e_core;
            rep  = mshr_deq_valid && e_deq;
            fl   = m_mode == M_FLUSH && room && m_sent < NL;
            chk("mshr_fill_valid", mshr_fill_valid, fill);
            if (fill) chk("mshr_fill_id", mshr_fill_id, mem_rsp_id);
            it = '0;
            if (fill) begin
                it.op = OP_FILL; it.addr = mshr_tab[mem_rsp_id]; it.line = mem_rsp_data; it.id = mem_rsp_id;
                exp_q.push_back(it);
            end
            if (rep) begin
                it.op = OP_REPLAY; it.addr = mshr_deq_addr; it.rw = mshr_deq_rw;
                it.data = mshr_deq_data; it.id = mshr_deq_id;
                exp_q.push_back(it);
            end
            if (fl) begin
                it.op = OP_FLUSH; it.addr = LA'(m_sent);
                exp_q.push_back(it);
            end
            if (core) begin
                it.op = OP_CORE; it.addr = core_req_addr; it.rw = core_req_rw; it.data = core_req_data;
                exp_q.push_back(it);
                if (cw) m_core_wins_seen++;
            end
            if (e_done) m_flush_done_seen++;
            if (room) m_pv = fill || rep || fl || core;
            if (!core_req_valid || core) m_starve = 0;
            else if (fill && mshr_alloc_ready && m_starve < SL) m_starve++;
            case (m_mode)
                M_IDLE: begin
                    if (fill) m_mode = M_FW;
                    else if (fblk && room) begin m_mode = M_FLUSH; m_sent = 0; m_pend = 0; end
                end
                M_FW:     m_mode = M_REPLAY;
                M_REPLAY: if (!mshr_deq_valid) m_mode = M_IDLE;
                default: begin
                    if (fl) m_sent++;
                    if (e_done) m_mode = M_IDLE;
                end
            endcase
            if (flush_begin) m_pend = 1;
        end
    end

    // Scoreboard monitor: whatever the output register shows must be the oldest expected op.
    always @(posedge clk) begin : mon_p
        item_t e;
        #2;
        if (!reset) begin
            chk("pipe_valid", pipe_valid, exp_q.size() != 0);
            if (pipe_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                chk("pipe_op", pipe_op, e.op);
                chk("pipe_addr", pipe_addr, e.addr);
                chk("pipe_rw", pipe_rw, e.rw);
                chk("pipe_data", pipe_data, e.data);
                chk("pipe_line", pipe_line, e.line);
                chk("pipe_id", pipe_id, e.id);
                if (pipe_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit found;
        for (int i = 0; i < MS; i++) mshr_tab[i] = LA'($urandom);

        // Reset state, with sources already asserting.
        mem_rsp_valid = 1; core_req_valid = 1; mshr_deq_valid = 1; mshr_alloc_ready = 1;
        #12;
        chk_reset_outputs("rst");
        chk("rst_core_req_ready_memvalid", core_req_ready, 0);
        mem_rsp_valid = 0;
        #1;
        chk("rst_core_req_ready_comb", core_req_ready, 1);
        quiet_inputs();
        @(posedge clk);
        #3 reset = 0;

        knobs(90, 0, 0, 100, 0, 0, 100);   drive(30);    // core only
        knobs(90, 0, 0, 0, 0, 0, 100);     drive(10);    // no MSHR slot
        knobs(100, 100, 0, 100, 0, 0, 100); drive(40);   // starvation
        knobs(70, 50, 60, 70, 0, 0, 30);   drive(300);   // heavy backpressure
        knobs(60, 40, 50, 80, 50, 5, 70);  drive(600);   // flushes
        knobs(50, 50, 60, 60, 30, 2, 60);  drive(1000);  // general mix

        // Asynchronous reset while a replay chain is draining.
        knobs(0, 100, 90, 100, 0, 0, 100);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            drive(1);
            if (m_mode == M_REPLAY) found = 1;
        end
        chk("reach_replay", found, 1);
        #2 reset = 1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        quiet_inputs();
        @(posedge clk);
        #3 reset = 0;

        knobs(50, 50, 60, 60, 40, 3, 60);  drive(300);

        // Drain: let any pending flush complete and the output register empty.
        knobs(0, 0, 0, 100, 100, 0, 100);  drive(40);
        #2;
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
        chk("starve_core_won", m_core_wins_seen > 0, 1);
        chk("flush_completed", m_flush_done_seen > 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
